sub64_arbiter: RTL and testbench

Sequencer and two-port round-robin arbiter for the shared 64-bit subtractor. Two requesters share one subtraction datapath: the execute-stage compare unit (port 0) and the stack-pointer/address unit (port 1). The block accepts one request at a time with a valid/ready handshake and registers the operands. It computes A − B on the shared subtractor and returns the registered difference plus condition flags on the owning port's response channel.

---
 rtl/sub64_arbiter_if.sv | 30 +++
 rtl/sub64_arbiter.sv | 149 ++++++++++++++
 tb/tb_sub64_arbiter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/sub64_arbiter_if.sv
// Request/response bundle for the shared 64-bit subtractor arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface sub64_arbiter_if #(
  parameter int unsigned WIDTH = 64
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b1;
  logic [1:0]       rsp_valid;
  logic [1:0]       rsp_ready;
  logic [WIDTH-1:0] rsp_y;
  logic             rsp_zf;
  logic             rsp_sf;
  logic             rsp_of;
  logic             rsp_bw;
  logic             busy;

  modport slave (
    input  req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    output req_ready, rsp_valid, rsp_y, rsp_zf, rsp_sf, rsp_of, rsp_bw, busy
  );

  modport master (
    output req_valid, req_a0, req_b0, req_a1, req_b1, rsp_ready,
    input  req_ready, rsp_valid, rsp_y, rsp_zf, rsp_sf, rsp_of, rsp_bw, busy
  );
endinterface

// File: rtl/sub64_arbiter.sv
// Two-port round-robin arbiter and sequencer around one shared 64-bit subtractor.
// One operation in flight: IDLE accepts, EXEC computes and registers, DONE returns the result.
module sub64_arbiter #(
  parameter int unsigned WIDTH = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  sub64_arbiter_if.slave bus_io
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             zf_q, zf_d;
  logic             sf_q, sf_d;
  logic             of_q, of_d;
  logic             bw_q, bw_d;

  logic             gnt;
  logic             gnt_vld;
  logic             accept;
  logic             rsp_done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Extra top bit of the widened subtraction is the unsigned borrow.
  assign {borrow, diff} = {1'b0, op_a_q} - {1'b0, op_b_q};

  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    case (bus_io.req_valid)
      2'b01: begin
        gnt_vld = 1'b1;
        gnt     = 1'b0;
      end
      2'b10: begin
        gnt_vld = 1'b1;
        gnt     = 1'b1;
      end
      2'b11: begin
        gnt_vld = 1'b1;
        gnt     = ~last_grant_q;
      end
      default: begin
        gnt_vld = 1'b0;
        gnt     = 1'b0;
      end
    endcase
  end

  assign accept   = (state_q == StIdle) && |(bus_io.req_valid & bus_io.req_ready);
  assign rsp_done = (state_q == StDone) && bus_io.rsp_ready[owner_q];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      y_q          <= '0;
      zf_q         <= 1'b0;
      sf_q         <= 1'b0;
      of_q         <= 1'b0;
      bw_q         <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      y_q          <= y_d;
      zf_q         <= zf_d;
      sf_q         <= sf_d;
      of_q         <= of_d;
      bw_q         <= bw_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    y_d          = y_q;
    zf_d         = zf_q;
    sf_d         = sf_q;
    of_d         = of_q;
    bw_d         = bw_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_a_d       = gnt ? bus_io.req_a1 : bus_io.req_a0;
          op_b_d       = gnt ? bus_io.req_b1 : bus_io.req_b0;
          owner_d      = gnt;
          last_grant_d = gnt;
          state_d      = StExec;
        end
      end
      StExec: begin
        y_d     = diff;
        zf_d    = (diff == '0);
        sf_d    = diff[WIDTH-1];
        of_d    = (op_a_q[WIDTH-1] != op_b_q[WIDTH-1]) && (diff[WIDTH-1] != op_a_q[WIDTH-1]);
        bw_d    = borrow;
        state_d = StDone;
      end
      StDone: begin
        if (rsp_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.req_ready = 2'b00;
    bus_io.rsp_valid = 2'b00;
    bus_io.busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rst_n && gnt_vld) begin
          bus_io.req_ready[gnt] = 1'b1;
        end
      end
      StExec: bus_io.busy = 1'b1;
      StDone: begin
        bus_io.busy               = 1'b1;
        bus_io.rsp_valid[owner_q] = 1'b1;
      end
      default: bus_io.busy = 1'b0;
    endcase
  end

  assign bus_io.rsp_y  = y_q;
  assign bus_io.rsp_zf = zf_q;
  assign bus_io.rsp_sf = sf_q;
  assign bus_io.rsp_of = of_q;
  assign bus_io.rsp_bw = bw_q;

endmodule

// File: tb/tb_sub64_arbiter.sv
// Directed bench for sub64_arbiter: arithmetic flags, round-robin grants,
// response backpressure and reset in the middle of an operation.
module tb_sub64_arbiter;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  sub64_arbiter_if #(.WIDTH(64)) bus ();

  sub64_arbiter #(.WIDTH(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] flags();
    return {60'd0, bus.rsp_zf, bus.rsp_sf, bus.rsp_of, bus.rsp_bw};
  endfunction

  // Present a request, check the grant, then follow it through EXEC and DONE with rsp_ready=11.
  task automatic do_op(input string tag, input logic [1:0] vld, input logic [1:0] exp_gnt,
                       input logic [63:0] a0, input logic [63:0] b0,
                       input logic [63:0] a1, input logic [63:0] b1,
                       input logic [63:0] exp_y, input logic [3:0] exp_f);
    bus.req_valid = vld;
    bus.req_a0    = a0;
    bus.req_b0    = b0;
    bus.req_a1    = a1;
    bus.req_b1    = b1;
    bus.rsp_ready = 2'b11;
    #1;
    check({tag, ".req_ready"}, 64'(bus.req_ready), 64'(exp_gnt));
    tick();
    check({tag, ".exec_busy"}, 64'(bus.busy), 64'd1);
    check({tag, ".exec_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, ".exec_req_ready"}, 64'(bus.req_ready), 64'd0);
    tick();
    check({tag, ".rsp_valid"}, 64'(bus.rsp_valid), 64'(exp_gnt));
    check({tag, ".rsp_y"}, bus.rsp_y, exp_y);
    check({tag, ".flags"}, flags(), 64'(exp_f));
    tick();
    check({tag, ".idle_busy"}, 64'(bus.busy), 64'd0);
    check({tag, ".idle_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    bus.req_valid = 2'b11;
    bus.req_a0    = 64'd0;
    bus.req_b0    = 64'd0;
    bus.req_a1    = 64'd0;
    bus.req_b1    = 64'd0;
    bus.rsp_ready = 2'b00;

    tick();
    tick();
    check("rst.req_ready", 64'(bus.req_ready), 64'd0);
    check("rst.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst.busy", 64'(bus.busy), 64'd0);
    check("rst.rsp_y", bus.rsp_y, 64'd0);
    check("rst.flags", flags(), 64'd0);
    bus.req_valid = 2'b00;
    rst_n         = 1'b1;
    tick();
    check("idle.no_req", 64'(bus.req_ready), 64'd0);

    // flags are {zf, sf, of, bw}
    do_op("basic", 2'b01, 2'b01, 64'd5, 64'd3, 64'd0, 64'd0, 64'd2, 4'b0000);
    do_op("neg", 2'b10, 2'b10, 64'd0, 64'd0, 64'd3, 64'd5,
          64'hFFFF_FFFF_FFFF_FFFE, 4'b0101);
    do_op("equal", 2'b01, 2'b01, 64'h1234, 64'h1234, 64'd0, 64'd0, 64'd0, 4'b1000);
    do_op("ovf_pos", 2'b01, 2'b01, 64'h8000_0000_0000_0000, 64'd1, 64'd0, 64'd0,
          64'h7FFF_FFFF_FFFF_FFFF, 4'b0010);
    do_op("ovf_neg", 2'b10, 2'b10, 64'd0, 64'd0, 64'd0, 64'h8000_0000_0000_0000,
          64'h8000_0000_0000_0000, 4'b0111);

    // Last grant was port 1, so continuous contention must alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0)
        do_op("rr0", 2'b11, 2'b01, 64'd100, 64'd1, 64'd50, 64'd70, 64'd99, 4'b0000);
      else
        do_op("rr1", 2'b11, 2'b10, 64'd100, 64'd1, 64'd50, 64'd70,
              64'hFFFF_FFFF_FFFF_FFEC, 4'b0101);
    end

    // Backpressure: only the non-owner port is ready, which must be ignored.
    bus.req_valid = 2'b01;
    bus.req_a0    = 64'd10;
    bus.req_b0    = 64'd4;
    bus.rsp_ready = 2'b10;
    #1;
    check("bp.req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 2'b11;
    tick();
    for (int i = 0; i < 4; i++) begin
      bus.req_a0 = 64'(i + 20);
      tick();
      check("bp.rsp_valid", 64'(bus.rsp_valid), 64'd1);
      check("bp.rsp_y", bus.rsp_y, 64'd6);
      check("bp.req_ready", 64'(bus.req_ready), 64'd0);
      check("bp.busy", 64'(bus.busy), 64'd1);
    end
    bus.rsp_ready = 2'b01;
    tick();
    check("bp.release_busy", 64'(bus.busy), 64'd0);
    check("bp.release_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("bp.next_grant", 64'(bus.req_ready), 64'd2);
    check("bp.y_held", bus.rsp_y, 64'd6);

    // Reset while in EXEC: port 1 owns the op, afterwards a tie must go to port 0.
    bus.req_valid = 2'b10;
    bus.req_a1    = 64'd9;
    bus.req_b1    = 64'd2;
    bus.rsp_ready = 2'b11;
    tick();
    check("mid.exec_busy", 64'(bus.busy), 64'd1);
    bus.req_valid = 2'b11;
    rst_n         = 1'b0;
    tick();
    check("mid.rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("mid.rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("mid.busy", 64'(bus.busy), 64'd0);
    check("mid.rsp_y", bus.rsp_y, 64'd0);
    rst_n = 1'b1;
    do_op("mid.after", 2'b11, 2'b01, 64'd7, 64'd7, 64'd9, 64'd2, 64'd0, 4'b1000);
    bus.req_valid = 2'b00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
